// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe delay line.
//   DFF_WIDTH_DEF : default data width per stage
//   DFF_DEPTH_DEF : default number of register stages
//   clog2()       : ceiling log2, used to size the occupancy counter
package dff_pkg;

  localparam int DFF_WIDTH_DEF = 8;
  localparam int DFF_DEPTH_DEF = 4;

  // Smallest r with 2**r >= n (returns 0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One stage of the stallable delay line: WIDTH-bit data register plus valid bit.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of the valid bit (data holds)
//   up_valid    : valid from the previous stage (or pipeline input)
//   up_data     : data from the previous stage (or pipeline input)
//   down_ready  : next stage (or pipeline output) can take this stage's content
//   valid, data : registered stage contents
//   ready       : this stage can load this cycle (empty, or draining downstream)
module dff_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // An empty stage is a bubble and always accepts, which is what collapses
  // bubbles while the stages downstream are stalled.
  assign ready = !valid_q || down_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (ready) begin
      valid_d = up_valid;
      // Only capture real items; a bubble passing through leaves data untouched.
      if (up_valid) data_d = up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Stallable D-flip-flop delay line: DEPTH stages of WIDTH bits with valid/ready
// handshakes on both ends and bubble collapse while stalled.
// Optional feature macro: DFF_PIPE_FLUSH_EN adds a synchronous flush input.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_data   : upstream item; accepted when in_valid && in_ready
//   in_ready            : pipeline can accept this cycle
//   out_valid, out_data : last stage contents; delivered when out_valid && out_ready
//   out_ready           : downstream accepts this cycle
//   occupancy           : registered count of items held
//   flush               : (DFF_PIPE_FLUSH_EN only) drop all items at the clock edge
module dff_pipe
  import dff_pkg::*;
#(
  parameter  int WIDTH = DFF_WIDTH_DEF,
  parameter  int DEPTH = DFF_DEPTH_DEF,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CNT_W-1:0] occupancy
);

  logic             stg_valid [DEPTH];
  logic [WIDTH-1:0] stg_data  [DEPTH];
  logic             stg_ready [DEPTH+1];
  logic             clr;
  logic             in_acc;
  logic             out_acc;
  logic [CNT_W-1:0] occ_q, occ_d;

`ifdef DFF_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign stg_ready[DEPTH] = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (g == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_chain
      assign up_v = stg_valid[g-1];
      assign up_d = stg_data[g-1];
    end

    dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .up_valid   (up_v),
      .up_data    (up_d),
      .down_ready (stg_ready[g+1]),
      .valid      (stg_valid[g]),
      .data       (stg_data[g]),
      .ready      (stg_ready[g])
    );
  end

  // During a flush nothing may be accepted, otherwise an item would be counted
  // while the stage clear throws it away.
  assign in_ready  = stg_ready[0] && !clr;
  assign out_valid = stg_valid[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (in_acc && !out_acc) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (out_acc && !in_acc) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4): directed scenarios with
// literal expectations plus a randomized run checked every cycle against an
// item-position model of the delay line.
module tb_dff_pipe;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         flush_i = 1'b0;
  logic [2:0]   occupancy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: one entry per item held, oldest first; position 0..D-1 along the line.
  int           m_pos[$];
  logic [W-1:0] m_dat[$];
  logic [W-1:0] del_q[$];

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef DFF_PIPE_FLUSH_EN
    .flush     (flush_i),
`endif
    .occupancy (occupancy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // The line can take an item unless every stage holds one and nothing leaves.
  function automatic bit m_in_ready();
    return !flush_i && ((m_pos.size() < D) || out_ready);
  endfunction

  function automatic bit hole_after(input int p);
    for (int q = p + 1; q < D; q++) begin
      bit found;
      found = 1'b0;
      foreach (m_pos[k]) if (m_pos[k] == q) found = 1'b1;
      if (!found) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int           np[$];
    logic [W-1:0] nd[$];
    bit           acc;
    if (!rst_n) begin
      m_pos.delete();
      m_dat.delete();
    end else if (flush_i) begin
      m_pos.delete();
      m_dat.delete();
    end else begin
      np.delete();
      nd.delete();
      acc = in_valid && m_in_ready();
      foreach (m_pos[k]) begin
        if (m_pos[k] == D - 1) begin
          if (!out_ready) begin
            np.push_back(m_pos[k]);
            nd.push_back(m_dat[k]);
          end
        end else begin
          // An item moves up whenever there is free room anywhere ahead of it.
          np.push_back((out_ready || hole_after(m_pos[k])) ? m_pos[k] + 1 : m_pos[k]);
          nd.push_back(m_dat[k]);
        end
      end
      if (acc) begin
        np.push_back(0);
        nd.push_back(in_data);
      end
      m_pos = np;
      m_dat = nd;
    end
  end

  // Per-cycle compare against the model; also records every delivered item.
  always @(negedge clk) begin
    bit exp_ov;
    #2;
    if (rst_n && chk_en) begin
      exp_ov = (m_pos.size() > 0) && (m_pos[0] == D - 1);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) chk("out_data", out_data, m_dat[0]);
      chk("in_ready", in_ready, m_in_ready());
      chk("occupancy", occupancy, m_pos.size());
      if (out_valid && out_ready) del_q.push_back(out_data);
    end
  end

  task automatic drive(input bit iv, input logic [W-1:0] id, input bit ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush_i   = 1'b0;
    #3;
  endtask

  task automatic drain();
    repeat (8) drive(1'b0, '0, 1'b1);
  endtask

  task automatic chk_del(input string nm, input logic [W-1:0] first, input int n);
    chk({nm, "_count"}, del_q.size(), n);
    for (int i = 0; i < n && i < del_q.size(); i++)
      chk({nm, "_order"}, del_q[i], first + W'(i));
  endtask

  initial begin
    int first_ov;

    // 1. Reset with input activity.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk_en = 1'b1;

    // 2. Streaming.
    del_q.delete();
    first_ov = -1;
    for (int j = 0; j < 12; j++) begin
      drive(j < 8, W'(j + 1), 1'b1);
      if (out_valid && first_ov < 0) first_ov = j;
      if (j >= 4 && j <= 8) chk("stream_occupancy", occupancy, 4);
    end
    chk("stream_latency", first_ov, 4);
    chk_del("stream", 8'h01, 8);
    drain();

    // 3. Stall and fill, then release.
    del_q.delete();
    for (int j = 0; j < 4; j++) drive(1'b1, 8'h10 + W'(j), 1'b0);
    drive(1'b1, 8'h14, 1'b0);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_occupancy", occupancy, 4);
    drive(1'b1, 8'h14, 1'b1);
    chk("full_ripple_in_ready", in_ready, 1);
    drain();
    chk_del("fill", 8'h10, 5);

    // 4. Bubble collapse.
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 8'h21, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b0);
    chk("bubble_occupancy", occupancy, 2);
    chk("bubble_head", out_data, 8'h20);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("bubble_adjacent_valid", out_valid, 1);
    chk("bubble_adjacent_data", out_data, 8'h21);
    drain();

    // 5. Async reset mid-stream.
    repeat (3) drive(1'b1, W'($urandom), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("pre_reset_occupancy", occupancy, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_occupancy", occupancy, 0);
    #1;
    rst_n = 1'b1;

`ifdef DFF_PIPE_FLUSH_EN
    // 6. Flush.
    repeat (3) drive(1'b1, W'($urandom), 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b0;
    flush_i   = 1'b1;
    #3;
    chk("flush_in_ready", in_ready, 0);
    drive(1'b0, '0, 1'b0);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);
`endif

    // Randomized traffic.
    repeat (400) drive($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 3) != 0);
    drain();
    chk("final_empty", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
